fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage between the PC/redirect logic and the decode stage. Holds the program counter and issues one 32-bit instruction read at a time to the instruction cache using its four-phase read_enable/send_enable handshake. It presents each fetched instruction with its PC to decode through a one-entry valid/ready output register. Redirects from later stages flush the output register, and data from any request in flight is discarded.

## Interface
- RESET_PC, 64'h0: PC loaded on reset.
- ADDR_WIDTH, 64: PC and cache address width.
- clock  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- redirect_valid  in  1  load redirect_pc as the new fetch PC; flush.
- redirect_pc  in  ADDR_WIDTH  redirect target; bits [1:0] forced to 0.
- icache_read_enable  out  1  cache request, four-phase.
- icache_address  out  ADDR_WIDTH  request address; stable for the whole handshake.
- icache_data  in  32  instruction from the cache; valid while icache_send_enable=1.
- icache_send_enable  in  1  cache acknowledge / data valid.
- if_valid  out  1  output register holds an instruction.
- if_instr  out  32  instruction.
- if_pc  out  ADDR_WIDTH  PC of if_instr.
- id_ready  in  1  decode accepts the output this cycle when if_valid=1.

## Operation
- Reset values:
  - state=S_REQ, pc=RESET_PC, req_addr=RESET_PC, discard=0.
  - Outputs: icache_read_enable=0, if_valid=0, if_instr=0, if_pc=0.
  - icache_read_enable is a registered output; it rises the cycle after reset deasserts.
- S_REQ:
  - icache_read_enable=1 and icache_address=req_addr.
  - On icache_send_enable=1, go to S_REL.
  - If discard=0: load if_instr=icache_data, if_pc=req_addr, if_valid=1, and pc=req_addr+4 (modulo 2^ADDR_WIDTH; wrap allowed).
  - If discard=1: drop the data and clear discard.
- S_REL:
  - icache_read_enable=0, held for at least one cycle.
  - When icache_send_enable=0: if the slot is free, set req_addr=pc and go to S_REQ; otherwise go to S_WAIT.
  - Slot free means if_valid=0, or if_valid=1 and id_ready=1 in the same cycle.
- S_WAIT: read_enable=0. When the slot is free, set req_addr=pc and go to S_REQ.
- Output register: if_valid clears on an (if_valid && id_ready) handshake unless it is reloaded in the same cycle. It cannot be reloaded in the same cycle, because a request is issued only into a free slot.
- Redirect (any state, highest priority):
  - pc=redirect_pc & ~3 and if_valid=0.
  - In S_REQ without icache_send_enable: set discard=1. The handshake still completes, because the cache cannot abort.
  - In S_REQ with icache_send_enable=1 in the same cycle: drop the data, discard stays 0, go to S_REL.
  - In S_REL or S_WAIT: no further effect. The next request uses the new pc.
  - req_addr never changes while icache_read_enable=1.
- Redirect in the same cycle as an id_ready handshake: decode consumes the old if_instr, and the register is still flushed.
- Reset mid-handshake: return to reset values. icache_read_enable falls the next cycle, and the cache recovers through its own reset.

## Timing
- Request to capture: the capture edge is the first edge with icache_send_enable=1. With a cache hit that acknowledges 1 cycle after read_enable, if_valid rises 2 cycles after read_enable rises.
- Release: read_enable low at least 1 cycle; next read_enable rise at the earliest 1 cycle after icache_send_enable is seen low.
- Hit throughput with the 1-cycle-acknowledge / 1-cycle-release cache: one instruction per 4 cycles.
- Miss latency is cache-defined and unbounded; the fetch stage waits indefinitely.
- if_instr and if_pc are stable while if_valid=1 and id_ready=0.

## Structure
- Package fetch_pkg:
  - state enum fetch_state_t {S_REQ, S_REL, S_WAIT}, 2 bits.
  - localparam INSTR_BYTES=4.
  - localparam INSTR_WIDTH=32.
- No sub-module: the block is a single FSM plus the PC and output registers.

## Test plan
- Reset release with RESET_PC=64'h1000, and the cache model acks 1 cycle after request with data 32'h00000013 -> icache_address=64'h1000, if_valid=1 with if_pc=64'h1000, if_instr=32'h00000013; the next request uses 64'h1004.
- id_ready=0 for 10 cycles -> exactly one completed handshake and no new read_enable rise; if_instr is stable. After id_ready=1, the next request starts within 2 cycles.
- Redirect to 64'h2003 while in S_REQ on a 20-cycle miss -> icache_address stays the old value until ack; the acked data is dropped and the next request is 64'h2000.
- Redirect in the same cycle as send_enable -> data dropped, discard=0, next address = redirect target.
- PC 64'hFFFF_FFFF_FFFF_FFFC fetched -> next request 64'h0.
- Reset asserted in S_REQ with read_enable=1 -> the next cycle read_enable=0 and if_valid=0; the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_REL  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;
    localparam int INSTR_WIDTH = 32;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: holds the PC, runs the four-phase icache read handshake and
// presents each fetched instruction to decode through a one-entry valid/ready register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   icache_read_enable,
    output logic [ADDR_WIDTH-1:0]  icache_address,
    input  logic [INSTR_WIDTH-1:0] icache_data,
    input  logic                   icache_send_enable,
    output logic                   if_valid,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [ADDR_WIDTH-1:0]  if_pc,
    input  logic                   id_ready
);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  discard;

    logic [ADDR_WIDTH-1:0] redirect_target;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  slot_free;

    always_comb begin
        redirect_target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        // A redirect in the cycle a request is launched must already steer that request.
        pc_next         = redirect_valid ? redirect_target : pc;
        slot_free       = !if_valid || id_ready;
    end

    assign icache_address = req_addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= S_REQ;
            pc                 <= RESET_PC;
            req_addr           <= RESET_PC;
            discard            <= 1'b0;
            icache_read_enable <= 1'b0;
            if_valid           <= 1'b0;
            if_instr           <= '0;
            if_pc              <= '0;
        end else begin
            if (if_valid && id_ready) begin
                if_valid <= 1'b0;
            end

            case (state)
                S_REQ: begin
                    if (!icache_read_enable) begin
                        // First cycle out of reset: launch the request.
                        icache_read_enable <= 1'b1;
                        req_addr           <= pc_next;
                    end else if (icache_send_enable) begin
                        state              <= S_REL;
                        icache_read_enable <= 1'b0;
                        discard            <= 1'b0;
                        if (!discard && !redirect_valid) begin
                            if_instr <= icache_data;
                            if_pc    <= req_addr;
                            if_valid <= 1'b1;
                            pc       <= req_addr + ADDR_WIDTH'(INSTR_BYTES);
                        end
                    end else if (redirect_valid) begin
                        // The cache cannot abort; finish the handshake and drop its data.
                        discard <= 1'b1;
                    end
                end
                S_REL: begin
                    if (!icache_send_enable) begin
                        if (slot_free) begin
                            state              <= S_REQ;
                            req_addr           <= pc_next;
                            icache_read_enable <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (slot_free) begin
                        state              <= S_REQ;
                        req_addr           <= pc_next;
                        icache_read_enable <= 1'b1;
                    end
                end
                default: begin
                    state              <= S_REQ;
                    icache_read_enable <= 1'b0;
                end
            endcase

            if (redirect_valid) begin
                pc       <= redirect_target;
                if_valid <= 1'b0;
            end
        end
    end

endmodule
